biriscv_div_arbiter: RTL and testbench
======================================

// Module: biriscv_div_arbiter
// PURPOSE
//  Shares the single iterative divider between the two issue pipes of the dual-issue core.
//  Arbitrates DIV/DIVU/REM/REMU requests and sequences one operation into the divider at a time.
//  Tracks which pipe owns the in-flight op, steers the result back to that pipe with its rd index,
//  and handles flush and hung-divider timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  40  max WAIT cycles before abandoning op (>=34; divider worst case is 33)
//  CNT_W           6   width of WAIT counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk_i            in   1   clock
//  rst_i            in   1   reset, asynchronous, active-high
//  req0_valid_i     in   1   pipe0 divide request (asserted only for DIV/DIVU/REM/REMU)
//  req0_opcode_i    in   32  pipe0 instruction word
//  req0_ra_i        in   32  pipe0 operand A
//  req0_rb_i        in   32  pipe0 operand B
//  req0_rd_idx_i    in   5   pipe0 destination register
//  req0_accept_o    out  1   pipe0 request taken this cycle
//  req1_*           --   --  same five signals for pipe1 (valid/opcode/ra/rb/rd_idx/accept)
//  flush_i          in   1   pipeline flush; squash any owned/in-flight op
//  div_valid_o      out  1   issue strobe to divider opcode_valid_i (1 cycle)
//  div_opcode_o     out  32  to divider opcode_opcode_i
//  div_ra_o         out  32  to divider opcode_ra_operand_i
//  div_rb_o         out  32  to divider opcode_rb_operand_i
//  div_wb_valid_i   in   1   divider writeback_valid_o
//  div_wb_value_i   in   32  divider writeback_value_o
//  wb0_valid_o / wb1_valid_o    out  1   result for pipe0 / pipe1 (1-cycle pulse)
//  wb0_value_o / wb1_value_o    out  32  result value
//  wb0_rd_idx_o / wb1_rd_idx_o  out  5   owner's rd index
//  busy_o           out  1   state != IDLE (pipes stall new div issue)
//  timeout_o        out  1   1-cycle pulse when TIMEOUT_CYCLES expires
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, kill=0, counter=0, RR pointer=pipe0. Reset mid-op abandons it.
//  - FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//  - IDLE: grant (combinational) if any reqN_valid_i and !flush_i; reqN_accept_o=1 for winner only.
//    Handshake: transfer on valid&accept; requester holds valid/data until accepted.
//    On grant: latch opcode/ra/rb/rd_idx and owner id; go to ISSUE.
//  - ISSUE (1 cycle): div_valid_o=1 with latched opcode/ra/rb; counter cleared; go to WAIT.
//    div_* data outputs hold latched values at all times; valid only in ISSUE.
//  - WAIT: counter +1 per cycle. On div_wb_valid_i: if !kill pulse owner's wbN_valid_o
//    next cycle with registered value/rd_idx; other pipe's wb_valid stays 0. Go to IDLE.
//  - Timeout: counter reaches TIMEOUT_CYCLES with no wb -> timeout_o pulse, no writeback, IDLE.
//    wb and timeout in the same cycle: wb wins, no timeout.
//  - Flush in ISSUE or WAIT sets kill; strobe still issued; result consumed silently; kill
//    cleared on return to IDLE. Flush in IDLE blocks grant that cycle.
//  - div_wb_valid_i in IDLE/ISSUE (stray/late result): ignored, no wb pulse.
//  - No accept while busy; next grant earliest in the cycle after return to IDLE.
//  - Divider repeat-operand shortcut (completes fast) needs no special handling.
//  - Throughput: one op at a time; min accept-to-wb = 2 + divider latency + 1 cycles.
// CONFIGURATION
//  DIV_ARB_RR_EN defined: round-robin. Pointer flips to the other pipe after each grant;
//    on simultaneous requests the pointer's pipe wins.
//  Undefined: fixed priority, pipe0 always wins on simultaneous requests; no pointer state.
// TESTING
//  1. req0 DIVU ra=100 rb=7 rd=5, stub replies 14 after 33 cyc -> accept0 @t0, div_valid @t1
//     ra=100 rb=7, wb0_valid=1 value=14 rd_idx=5; wb1_valid=0; busy_o 0 after wb.
//  2. req0 & req1 both valid from IDLE, twice -> fixed: pipe0,pipe0 then pipe1;
//     RR_EN: pipe0 then pipe1, alternating; req1 data (rd=9) routed to wb1 only.
//  3. flush_i pulse 10 cyc into WAIT, stub replies -> no wb0/wb1 pulse, busy_o 0 next cycle,
//     following req1 accepted and written back normally.
//  4. Stub never replies, TIMEOUT_CYCLES=40 -> timeout_o pulse on 40th WAIT cycle, IDLE;
//     stray div_wb_valid_i 5 cyc later -> no wb pulse.
//  5. rst_i asserted mid-WAIT -> all outputs 0 async; post-reset req1 served first-come,
//     RR pointer back at pipe0.
//  6. wb and timeout coincide (stub replies at cycle 40) -> wb0 pulse, timeout_o=0.

Source files
------------

// File: rtl/biriscv_div_arbiter.sv
// rtl/biriscv_div_arbiter.sv - shares the single iterative divider between the two issue pipes
//
// Arbitrates DIV/DIVU/REM/REMU requests from pipe0 and pipe1 onto the one
// iterative divider, sequencing one operation at a time. The owning pipe and
// its rd index are remembered so the result is steered back to that pipe only.
// A flush squashes the owned op (the divider still runs it, the result is
// dropped), and a watchdog abandons the op if the divider never answers.
//
// Configuration macro: DIV_ARB_RR_EN
//   defined   - round-robin on simultaneous requests; the pointer moves to the
//               pipe that did not win after every grant
//   undefined - fixed priority, pipe0 wins on simultaneous requests
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT cycles allowed before the op is abandoned (>= 34)
//   CNT_W           WAIT counter width, must hold TIMEOUT_CYCLES
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req0_* / req1_*              per-pipe request valid/opcode/ra/rb/rd_idx, accept out
//   flush_i                      squash any owned or in-flight op; blocks grant in IDLE
//   div_valid_o                  1-cycle issue strobe to the divider
//   div_opcode_o/ra_o/rb_o       latched operands to the divider
//   div_wb_valid_i/value_i       divider result
//   wb0_* / wb1_*                per-pipe 1-cycle result pulse, value, rd index
//   busy_o                       an op is owned; pipes stall new divide issue
//   timeout_o                    1-cycle pulse when the divider fails to answer

module biriscv_div_arbiter #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        req0_valid_i,
  input  logic [31:0] req0_opcode_i,
  input  logic [31:0] req0_ra_i,
  input  logic [31:0] req0_rb_i,
  input  logic [4:0]  req0_rd_idx_i,
  output logic        req0_accept_o,

  input  logic        req1_valid_i,
  input  logic [31:0] req1_opcode_i,
  input  logic [31:0] req1_ra_i,
  input  logic [31:0] req1_rb_i,
  input  logic [4:0]  req1_rd_idx_i,
  output logic        req1_accept_o,

  input  logic        flush_i,

  output logic        div_valid_o,
  output logic [31:0] div_opcode_o,
  output logic [31:0] div_ra_o,
  output logic [31:0] div_rb_o,
  input  logic        div_wb_valid_i,
  input  logic [31:0] div_wb_value_i,

  output logic        wb0_valid_o,
  output logic [31:0] wb0_value_o,
  output logic [4:0]  wb0_rd_idx_o,
  output logic        wb1_valid_o,
  output logic [31:0] wb1_value_o,
  output logic [4:0]  wb1_rd_idx_o,

  output logic        busy_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Last WAIT count value; reaching it without a result means the divider hung.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;

  logic [31:0] opcode_q;
  logic [31:0] ra_q;
  logic [31:0] rb_q;
  logic [4:0]  rd_q;
  logic        owner_q;     // 0 = pipe0 owns the op, 1 = pipe1
  logic        kill_q;      // owned op was flushed; swallow its result
  logic [CNT_W-1:0] cnt_q;

  logic        wb0_valid_q;
  logic        wb1_valid_q;
  logic [31:0] wb_value_q;
  logic [4:0]  wb_rd_q;

  logic        grant0;
  logic        grant1;
  logic        grant;
  logic        can_grant;
  logic        wb_fire;

  assign can_grant = (state_q == ST_IDLE) && !flush_i;

  //--------------------------------------------------------------------------
  // Grant selection
  //--------------------------------------------------------------------------
`ifdef DIV_ARB_RR_EN
  logic rr_q;               // pipe favoured on the next simultaneous request

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_grant) begin
      if (req0_valid_i && req1_valid_i) begin
        grant0 = !rr_q;
        grant1 = rr_q;
      end else begin
        grant0 = req0_valid_i;
        grant1 = req1_valid_i;
      end
    end
  end

  // After a grant, favour the pipe that did not win.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= 1'b0;
    end else if (grant0 || grant1) begin
      rr_q <= grant0;
    end
  end
`else
  always_comb begin
    grant0 = can_grant && req0_valid_i;
    grant1 = can_grant && req1_valid_i && !req0_valid_i;
  end
`endif

  assign grant         = grant0 || grant1;
  assign req0_accept_o = grant0;
  assign req1_accept_o = grant1;

  //--------------------------------------------------------------------------
  // FSM next state and strobes
  //--------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    div_valid_o = 1'b0;
    timeout_o   = 1'b0;
    wb_fire     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The strobe goes out even if a flush is pending; the result is dropped later.
        div_valid_o = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the final count wins over the timeout.
        if (div_wb_valid_i) begin
          wb_fire = !(kill_q || flush_i);
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_o = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // State, operand latch, counter, kill and writeback registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      opcode_q    <= 32'd0;
      ra_q        <= 32'd0;
      rb_q        <= 32'd0;
      rd_q        <= 5'd0;
      owner_q     <= 1'b0;
      kill_q      <= 1'b0;
      cnt_q       <= '0;
      wb0_valid_q <= 1'b0;
      wb1_valid_q <= 1'b0;
      wb_value_q  <= 32'd0;
      wb_rd_q     <= 5'd0;
    end else begin
      state_q <= state_d;

      if (grant) begin
        owner_q  <= grant1;
        opcode_q <= grant1 ? req1_opcode_i : req0_opcode_i;
        ra_q     <= grant1 ? req1_ra_i     : req0_ra_i;
        rb_q     <= grant1 ? req1_rb_i     : req0_rb_i;
        rd_q     <= grant1 ? req1_rd_idx_i : req0_rd_idx_i;
      end

      if (state_q == ST_ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      // kill only lives while an op is owned; it is dropped on the way back to IDLE.
      if (state_q == ST_IDLE || state_d == ST_IDLE) begin
        kill_q <= 1'b0;
      end else if (flush_i) begin
        kill_q <= 1'b1;
      end

      wb0_valid_q <= wb_fire && !owner_q;
      wb1_valid_q <= wb_fire && owner_q;
      if (wb_fire) begin
        wb_value_q <= div_wb_value_i;
        wb_rd_q    <= rd_q;
      end
    end
  end

  assign div_opcode_o = opcode_q;
  assign div_ra_o     = ra_q;
  assign div_rb_o     = rb_q;

  assign wb0_valid_o  = wb0_valid_q;
  assign wb0_value_o  = wb_value_q;
  assign wb0_rd_idx_o = wb_rd_q;
  assign wb1_valid_o  = wb1_valid_q;
  assign wb1_value_o  = wb_value_q;
  assign wb1_rd_idx_o = wb_rd_q;

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_biriscv_div_arbiter.sv
// tb/tb_biriscv_div_arbiter.sv - self-checking bench for biriscv_div_arbiter

module tb_biriscv_div_arbiter;

  localparam int TO = 40;

  localparam logic [31:0] OP_DIV  = 32'h0200_4033;
  localparam logic [31:0] OP_DIVU = 32'h0200_5033;
  localparam logic [31:0] OP_REM  = 32'h0200_6033;
  localparam logic [31:0] OP_REMU = 32'h0200_7033;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic [31:0] req0_opcode_i, req0_ra_i, req0_rb_i;
  logic [31:0] req1_opcode_i, req1_ra_i, req1_rb_i;
  logic [4:0]  req0_rd_idx_i, req1_rd_idx_i;
  logic        req0_accept_o, req1_accept_o;
  logic        flush_i;
  logic        div_valid_o;
  logic [31:0] div_opcode_o, div_ra_o, div_rb_o;
  logic        div_wb_valid_i;
  logic [31:0] div_wb_value_i;
  logic        wb0_valid_o, wb1_valid_o;
  logic [31:0] wb0_value_o, wb1_value_o;
  logic [4:0]  wb0_rd_idx_o, wb1_rd_idx_o;
  logic        busy_o, timeout_o;

  biriscv_div_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_opcode_i(req0_opcode_i), .req0_ra_i(req0_ra_i),
    .req0_rb_i(req0_rb_i), .req0_rd_idx_i(req0_rd_idx_i), .req0_accept_o(req0_accept_o),
    .req1_valid_i(req1_valid_i), .req1_opcode_i(req1_opcode_i), .req1_ra_i(req1_ra_i),
    .req1_rb_i(req1_rb_i), .req1_rd_idx_i(req1_rd_idx_i), .req1_accept_o(req1_accept_o),
    .flush_i(flush_i),
    .div_valid_o(div_valid_o), .div_opcode_o(div_opcode_o), .div_ra_o(div_ra_o),
    .div_rb_o(div_rb_o), .div_wb_valid_i(div_wb_valid_i), .div_wb_value_i(div_wb_value_i),
    .wb0_valid_o(wb0_valid_o), .wb0_value_o(wb0_value_o), .wb0_rd_idx_o(wb0_rd_idx_o),
    .wb1_valid_o(wb1_valid_o), .wb1_value_o(wb1_value_o), .wb1_rd_idx_o(wb1_rd_idx_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic        pipe;
    logic [31:0] opcode;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rd;
    int          lat;     // WAIT cycle in which the stub replies (0 = never)
    logic [31:0] reply;   // stub result = expected writeback value
  } op_t;

  typedef struct {
    logic        pipe;
    logic [31:0] value;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Divider stub: replies stub_lat WAIT cycles after the issue strobe.
  int          stub_lat = 0;
  logic [31:0] stub_reply = 32'd0;
  int          stub_reply_cyc = -1;

  initial begin
    div_wb_valid_i = 1'b0;
    div_wb_value_i = 32'd0;
    forever begin
      @(negedge clk_i);
      if (div_valid_o && stub_lat > 0) begin
        repeat (stub_lat) @(negedge clk_i);
        div_wb_valid_i = 1'b1;
        div_wb_value_i = stub_reply;
        stub_reply_cyc = cyc;
        @(negedge clk_i);
        div_wb_valid_i = 1'b0;
      end
    end
  end

  // Scoreboard: every writeback pulse must match the oldest expected result.
  always @(negedge clk_i) begin
    if (wb0_valid_o || wb1_valid_o) begin
      chk("wb_one_pipe_only", 32'(wb0_valid_o & wb1_valid_o), 32'd0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wb_unexpected: got wb0=%b wb1=%b expected no writeback (cycle %0d)",
                 wb0_valid_o, wb1_valid_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_pipe", 32'(wb1_valid_o), 32'(e.pipe));
        chk("wb_value", e.pipe ? wb1_value_o : wb0_value_o, e.value);
        chk("wb_rd_idx", 32'(e.pipe ? wb1_rd_idx_o : wb0_rd_idx_o), 32'(e.rd));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic set_req(input op_t op);
    if (op.pipe) begin
      req1_valid_i = 1'b1; req1_opcode_i = op.opcode; req1_ra_i = op.ra;
      req1_rb_i = op.rb; req1_rd_idx_i = op.rd;
    end else begin
      req0_valid_i = 1'b1; req0_opcode_i = op.opcode; req0_ra_i = op.ra;
      req0_rb_i = op.rb; req0_rd_idx_i = op.rd;
    end
  endtask

  task automatic clr_req(input logic pipe);
    if (pipe) req1_valid_i = 1'b0;
    else      req0_valid_i = 1'b0;
  endtask

  task automatic wait_accept(output logic a0, output logic a1);
    int n = 0;
    while (!(req0_accept_o || req1_accept_o) && n < 80) begin
      tick();
      #1;
      n++;
    end
    a0 = req0_accept_o;
    a1 = req1_accept_o;
    if (!(a0 || a1)) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_wait: got no accept expected accept within %0d cycles", n);
    end
  endtask

  task automatic wait_wb(input string tag);
    int   n = 0;
    logic got = 1'b0;
    logic seen_to = 1'b0;
    while (!got && n < 100) begin
      tick();
      n++;
      if (timeout_o) seen_to = 1'b1;
      if (wb0_valid_o || wb1_valid_o) got = 1'b1;
    end
    chk({tag, "_wb_seen"}, 32'(got), 32'd1);
    chk({tag, "_wb_latency"}, cyc, stub_reply_cyc + 1);
    chk({tag, "_busy_after_wb"}, 32'(busy_o), 32'd0);
    chk({tag, "_no_timeout"}, 32'(seen_to), 32'd0);
  endtask

  task automatic run_op(input op_t op);
    logic a0, a1;
    stub_lat   = op.lat;
    stub_reply = op.reply;
    tick();
    set_req(op);
    #1;
    wait_accept(a0, a1);
    chk("vec_accept_own", 32'(op.pipe ? a1 : a0), 32'd1);
    chk("vec_accept_other", 32'(op.pipe ? a0 : a1), 32'd0);
    sb.push_back('{op.pipe, op.reply, op.rd});
    tick();
    clr_req(op.pipe);
    chk("vec_div_valid", 32'(div_valid_o), 32'd1);
    chk("vec_div_opcode", div_opcode_o, op.opcode);
    chk("vec_div_ra", div_ra_o, op.ra);
    chk("vec_div_rb", div_rb_o, op.rb);
    chk("vec_busy_issue", 32'(busy_o), 32'd1);
    wait_wb("vec");
  endtask

  op_t vec[7];
  op_t p0a, p0b, p1c, fa, fb;
  logic exp_order[3];
  logic a0, a1;
  int   i0, i1, to_k, gone;
  logic acc_busy;

  initial begin
    vec[0] = '{1'b0, OP_DIVU, 32'd100, 32'd7, 5'd5, 33, 32'd14};
    vec[1] = '{1'b1, OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd9, 20, 32'hFFFF_FFFA};
    vec[2] = '{1'b0, OP_REM, 32'd17, 32'd5, 5'd12, 1, 32'd2};
    vec[3] = '{1'b1, OP_REMU, 32'hFFFF_FFFF, 32'd16, 5'd31, 2, 32'd15};
    vec[4] = '{1'b0, OP_DIVU, 32'd1000, 32'd10, 5'd1, 39, 32'd100};
    vec[5] = '{1'b0, OP_DIVU, 32'd64, 32'd8, 5'd2, 40, 32'd8};
    vec[6] = '{1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 34, 32'h8000_0000};

    rst_i = 1'b1; flush_i = 1'b0;
    req0_valid_i = 1'b0; req0_opcode_i = 32'd0; req0_ra_i = 32'd0; req0_rb_i = 32'd0; req0_rd_idx_i = 5'd0;
    req1_valid_i = 1'b0; req1_opcode_i = 32'd0; req1_ra_i = 32'd0; req1_rb_i = 32'd0; req1_rd_idx_i = 5'd0;

    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_div_valid", 32'(div_valid_o), 32'd0);
    chk("rst_div_ra", div_ra_o, 32'd0);
    chk("rst_wb0_valid", 32'(wb0_valid_o), 32'd0);
    chk("rst_wb1_valid", 32'(wb1_valid_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    rst_i = 1'b0;

    // Table of single operations, including wb on the final timeout count
    for (int v = 0; v < 7; v++) run_op(vec[v]);

    // Simultaneous requests: pipe0 has two ops, pipe1 one (rd=9)
    p0a = '{1'b0, OP_DIVU, 32'd50, 32'd5, 5'd3, 3, 32'h111};
    p0b = '{1'b0, OP_REMU, 32'd51, 32'd5, 5'd4, 3, 32'h222};
    p1c = '{1'b1, OP_DIV, 32'd90, 32'd9, 5'd9, 3, 32'h999};
`ifdef DIV_ARB_RR_EN
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
`else
    exp_order[0] = 1'b0; exp_order[1] = 1'b0; exp_order[2] = 1'b1;
`endif
    stub_lat = 3;
    i0 = 0; i1 = 0;
    tick();
    set_req(p0a);
    set_req(p1c);
    #1;
    for (int g = 0; g < 3; g++) begin
      wait_accept(a0, a1);
      chk("race_single_accept", 32'(a0 ^ a1), 32'd1);
      chk("race_grant_pipe", 32'(a1), 32'(exp_order[g]));
      if (a1) begin
        stub_reply = p1c.reply;
        sb.push_back('{1'b1, p1c.reply, p1c.rd});
        i1++;
      end else begin
        stub_reply = (i0 == 0) ? p0a.reply : p0b.reply;
        sb.push_back('{1'b0, stub_reply, (i0 == 0) ? p0a.rd : p0b.rd});
        i0++;
      end
      tick();
      if (i0 == 1) set_req(p0b);
      else if (i0 >= 2) clr_req(1'b0);
      if (i1 >= 1) clr_req(1'b1);
      wait_wb("race");
      #1;
    end

    // Flush 10 cycles into WAIT; req1 held while busy, served afterwards
    fa = '{1'b0, OP_DIVU, 32'd77, 32'd7, 5'd6, 20, 32'hBAD0_0001};
    fb = '{1'b1, OP_DIVU, 32'd88, 32'd8, 5'd9, 6, 32'd11};
    stub_lat = fa.lat; stub_reply = fa.reply;
    tick();
    set_req(fa);
    #1;
    wait_accept(a0, a1);
    chk("flush_accept0", 32'(a0), 32'd1);
    tick();
    clr_req(1'b0);
    set_req(fb);
    stub_lat = fb.lat;
    acc_busy = 1'b0;
    for (int k = 1; k < 10; k++) begin
      tick();
      acc_busy = acc_busy | req1_accept_o;
    end
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    gone = -1;
    for (int k = 0; k < 40 && gone < 0; k++) begin
      tick();
      if (busy_o) acc_busy = acc_busy | req1_accept_o;
      else gone = cyc;
    end
    chk("flush_busy_drop", gone, stub_reply_cyc + 1);
    chk("no_accept_while_busy", 32'(acc_busy), 32'd0);
    #1;
    chk("accept1_after_idle", 32'(req1_accept_o), 32'd1);
    stub_reply = fb.reply;
    sb.push_back('{1'b1, fb.reply, fb.rd});
    tick();
    clr_req(1'b1);
    chk("flush_next_div_ra", div_ra_o, fb.ra);
    wait_wb("after_flush");

    // Flush in IDLE blocks grant; flush in ISSUE still strobes but drops the result
    stub_lat = 3; stub_reply = 32'hBAD0_0002;
    tick();
    set_req(fa);
    flush_i = 1'b1;
    #1;
    chk("flush_idle_blocks", 32'(req0_accept_o), 32'd0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("accept_after_flush_idle", 32'(req0_accept_o), 32'd1);
    tick();
    clr_req(1'b0);
    flush_i = 1'b1;
    chk("strobe_despite_flush", 32'(div_valid_o), 32'd1);
    tick();
    flush_i = 1'b0;
    repeat (6) tick();
    chk("flush_issue_idle", 32'(busy_o), 32'd0);

    // Divider never answers in time; stray result 5 cycles after the timeout
    stub_lat = 45; stub_reply = 32'hBAD0_0003;
    tick();
    set_req(vec[0]);
    #1;
    wait_accept(a0, a1);
    chk("to_accept0", 32'(a0), 32'd1);
    tick();
    clr_req(1'b0);
    to_k = -1;
    for (int k = 1; k <= 60 && to_k < 0; k++) begin
      tick();
      if (timeout_o) to_k = k;
    end
    chk("timeout_wait_cycle", to_k, TO);
    tick();
    chk("timeout_pulse_width", 32'(timeout_o), 32'd0);
    chk("busy_after_timeout", 32'(busy_o), 32'd0);
    repeat (8) tick();
    chk("busy_after_stray", 32'(busy_o), 32'd0);

    // Reset mid-WAIT, then pointer back at pipe0 and req1 served
    stub_lat = 0;
    tick();
    set_req(vec[4]);
    #1;
    wait_accept(a0, a1);
    tick();
    clr_req(1'b0);
    repeat (5) tick();
    rst_i = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_div_valid", 32'(div_valid_o), 32'd0);
    chk("midrst_div_ra", div_ra_o, 32'd0);
    chk("midrst_div_opcode", div_opcode_o, 32'd0);
    chk("midrst_timeout", 32'(timeout_o), 32'd0);
    tick(); tick();
    rst_i = 1'b0;
    stub_lat = 4; stub_reply = 32'h55;
    set_req(p0a);
    set_req(p1c);
    #1;
    wait_accept(a0, a1);
    chk("postrst_ptr_pipe0", 32'(a0), 32'd1);
    chk("postrst_ptr_not_pipe1", 32'(a1), 32'd0);
    sb.push_back('{1'b0, 32'h55, p0a.rd});
    tick();
    clr_req(1'b0);
    wait_wb("postrst0");
    #1;
    stub_reply = 32'h66;
    wait_accept(a0, a1);
    chk("postrst_req1_served", 32'(a1), 32'd1);
    sb.push_back('{1'b1, 32'h66, p1c.rd});
    tick();
    clr_req(1'b1);
    wait_wb("postrst1");

    repeat (3) tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
